// File: rtl/dec16_timer.sv
// dec16_timer: loadable countdown timer with one-shot or auto-reload expiry.
//
// Holds a reload value and a live count. While running, the count drops by
// one on every cycle with en high. When an enabled cycle sees count == 1 the
// timer expires: done pulses for one cycle and the count either reloads
// (auto_reload with a non-zero reload value) or goes to 0 and the timer idles.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (clears state, count, reload)
//   load         capture load_val into the reload register and the count
//   load_val     value written by load
//   start        begin counting (IDLE only); count == 0 gives an immediate done
//   stop         abort counting (RUN only); count holds
//   en           count-enable tick
//   auto_reload  on expiry, reload and keep running
//   count        current count (registered)
//   busy         high while running
//   done         one-cycle expiry pulse (registered)
module dec16_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;

  // Decrement as count + all-ones with carry-in 0, built as a ripple chain of
  // full-adder cells. The carry out of the top bit is the mod-2^WIDTH overflow
  // and is deliberately not formed.
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign dec[i] = count[i] ^ ONES[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (count[i] & ONES[i]) | (count[i] & carry[i]) |
                          (ONES[i] & carry[i]);
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    done_nxt   = 1'b0;

    if (load) begin
      reload_nxt = load_val;
      count_nxt  = load_val;
      state_nxt  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // A zero count is a zero-length timer: expire without running.
            if (count != '0) state_nxt = RUN;
            else             done_nxt  = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt = IDLE;
          end else if (en) begin
            // Terminal case is tested first so the count never wraps
            // through 0 to all-ones while running.
            if (count == WIDTH'(1)) begin
              done_nxt = 1'b1;
              if (auto_reload && reload != '0) begin
                count_nxt = reload;
              end else begin
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end else begin
              count_nxt = dec;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      done   <= done_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_dec16_timer.sv
// Testbench for dec16_timer: a directed vector table covering reset, one-shot,
// gated ticks, auto-reload, input priorities and count boundaries, followed by
// a randomized run checked against a behavioural model.
module tb_dec16_timer;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        en;
  logic        auto_reload;
  logic [15:0] count;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  dec16_timer #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          load;
    bit          start;
    bit          stop;
    bit          en;
    bit          ar;
    logic [15:0] lv;
    logic [15:0] e_count;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit ld, input bit st, input bit sp,
                     input bit e, input bit ar, input logic [15:0] lv,
                     input logic [15:0] ec, input bit eb, input bit ed);
    vec_t v;
    v.rst_n = r; v.load = ld; v.start = st; v.stop = sp; v.en = e; v.ar = ar;
    v.lv = lv; v.e_count = ec; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit r, input bit ld, input bit st, input bit sp,
                       input bit e, input bit ar, input logic [15:0] lv);
    rst_n = r; load = ld; start = st; stop = sp; en = e; auto_reload = ar;
    load_val = lv;
  endtask

  // Behavioural reference state
  logic [15:0] m_cnt, m_rl;
  bit          m_run, m_done;

  task automatic model_step(input bit r, input bit ld, input bit st,
                            input bit sp, input bit e, input bit ar,
                            input logic [15:0] lv);
    if (!r) begin
      m_cnt = 0; m_rl = 0; m_run = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (ld) begin
        m_rl = lv; m_cnt = lv; m_run = 0;
      end else if (m_run && sp) begin
        m_run = 0;
      end else if (!m_run && st) begin
        if (m_cnt == 0) m_done = 1;
        else            m_run  = 1;
      end else if (m_run && e) begin
        if (m_cnt == 1) begin
          m_done = 1;
          if (ar && m_rl != 0) m_cnt = m_rl;
          else begin
            m_cnt = 0; m_run = 0;
          end
        end else begin
          m_cnt = m_cnt - 16'd1;
        end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 16'h0);

    //   rst ld st sp en ar  lv        count    busy done
    // reset state
    add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    // reset mid-RUN, then zero-length start
    add(1, 1, 0, 0, 0, 0, 16'd5,    16'd5,    0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd0,    16'd5,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd4,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd3,    1, 0);
    add(0, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd0,    16'd0,    0, 1);
    add(1, 0, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0);
    // one-shot from 3
    add(1, 1, 0, 0, 0, 0, 16'd3,    16'd3,    0, 0);
    add(1, 0, 1, 0, 1, 0, 16'd0,    16'd3,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd2,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 1);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 0);
    // gated ticks 1,0,0,1
    add(1, 1, 0, 0, 0, 0, 16'd2,    16'd2,    0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd0,    16'd2,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 0, 0, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 0, 0, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 1);
    // auto-reload with period 2
    add(1, 1, 0, 0, 0, 1, 16'd2,    16'd2,    0, 0);
    add(1, 0, 1, 0, 0, 1, 16'd0,    16'd2,    1, 0);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd2,    1, 1);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd2,    1, 1);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd2,    1, 1);
    add(1, 0, 0, 0, 1, 1, 16'd0,    16'd1,    1, 0);
    // stop beats a same-cycle terminal decrement
    add(1, 0, 0, 1, 1, 1, 16'd0,    16'd1,    0, 0);
    // load beats start
    add(1, 1, 1, 0, 1, 0, 16'd7,    16'd7,    0, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd7,    0, 0);
    // start with stop in IDLE still starts; stop in RUN halts
    add(1, 1, 0, 0, 0, 0, 16'd4,    16'd4,    0, 0);
    add(1, 0, 1, 1, 0, 0, 16'd0,    16'd4,    1, 0);
    add(1, 0, 0, 1, 0, 0, 16'd0,    16'd4,    0, 0);
    // all-ones boundary
    add(1, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd0,    16'hFFFF, 1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'hFFFE, 1, 0);
    add(1, 0, 0, 1, 0, 0, 16'd0,    16'hFFFE, 0, 0);
    // count of 1 expires after one tick
    add(1, 1, 0, 0, 0, 0, 16'd1,    16'd1,    0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd0,    16'd1,    1, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 1);
    // zero-length timer never busy
    add(1, 1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0);
    add(1, 0, 1, 0, 1, 0, 16'd0,    16'd0,    0, 1);
    add(1, 0, 0, 0, 1, 0, 16'd0,    16'd0,    0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].load, vecs[i].start, vecs[i].stop,
            vecs[i].en, vecs[i].ar, vecs[i].lv);
      @(posedge clk);
      #1;
      chk("count", i, count, vecs[i].e_count);
      chk("busy",  i, {15'b0, busy}, {15'b0, vecs[i].e_busy});
      chk("done",  i, {15'b0, done}, {15'b0, vecs[i].e_done});
    end

    // Randomized run against the behavioural model
    drive(0, 0, 0, 0, 0, 0, 16'h0);
    model_step(0, 0, 0, 0, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      bit          r, ld, st, sp, e, ar;
      logic [15:0] lv;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ar = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                       : 16'($urandom_range(0, 6));
      drive(r, ld, st, sp, e, ar, lv);
      model_step(r, ld, st, sp, e, ar, lv);
      @(posedge clk);
      #1;
      chk("rnd_count", i, count, m_cnt);
      chk("rnd_busy",  i, {15'b0, busy}, {15'b0, m_run});
      chk("rnd_done",  i, {15'b0, done}, {15'b0, m_done});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
